mda_hbridge_pwm: RTL and testbench

//  Per-motor H-bridge drive stage, instantiated once per motor by the motor-control Avalon slave.

---
 rtl/mda_hbridge_pwm_pkg.sv | 35 +++
 rtl/mda_hbridge_pwm_if.sv | 26 ++
 rtl/mda_hbridge_pwm_counter.sv | 63 ++++++
 rtl/mda_hbridge_pwm.sv | 116 +++++++++++
 tb/tb_mda_hbridge_pwm.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mda_hbridge_pwm_pkg.sv
// Shared definitions for the H-bridge PWM drive stage: default widths, drive-state
// encoding, gate bit positions and the direction-to-gate mapping.
package mda_hbridge_pwm_pkg;

  localparam int unsigned PeriodLengthDefault = 16;
  localparam int unsigned DeadtimeDefault     = 50;

  // Gate bit positions on the 4-bit gate bus.
  localparam int unsigned GateAHi = 0;
  localparam int unsigned GateALo = 1;
  localparam int unsigned GateBHi = 2;
  localparam int unsigned GateBLo = 3;

  typedef enum logic [1:0] {
    StOff   = 2'b00,
    StDead  = 2'b01,
    StDrive = 2'b10
  } state_e;

  // Forward: A high side chops, B low side held on. Reverse: mirror image.
  // Each leg only ever has one of its two switches on.
  function automatic logic [3:0] gate_map(input logic dir, input logic pwm);
    logic [3:0] g;
    g = '0;
    if (!dir) begin
      g[GateAHi] = pwm;
      g[GateBLo] = 1'b1;
    end else begin
      g[GateBHi] = pwm;
      g[GateALo] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mda_hbridge_pwm_if.sv
// Control/status bundle between the motor-control slave registers and one H-bridge drive stage.
//   on, dir, period, duty_cycle : register values driven by the slave (master side)
//   gate, active, period_tick   : drive-stage outputs (slave side)
interface mda_hbridge_pwm_if #(
  parameter int unsigned PERIOD_LENGTH = mda_hbridge_pwm_pkg::PeriodLengthDefault
) ();

  logic                     on;
  logic                     dir;
  logic [PERIOD_LENGTH-1:0] period;
  logic [PERIOD_LENGTH-1:0] duty_cycle;
  logic [3:0]               gate;
  logic                     active;
  logic                     period_tick;

  modport master (
    output on, dir, period, duty_cycle,
    input  gate, active, period_tick
  );

  modport slave (
    input  on, dir, period, duty_cycle,
    output gate, active, period_tick
  );

endinterface

// File: rtl/mda_hbridge_pwm_counter.sv
// PWM period counter with shadowed duty/period.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   run_i          : advance the counter this cycle (staying in drive)
//   restart_i      : start a fresh period at cnt=0 and load shadows from the inputs
//   period_i       : requested period (loaded into the shadow on restart or wrap)
//   duty_i         : requested high time (loaded into the shadow on restart or wrap)
//   wrap_o         : current count is the last of the period
//   pwm_next_o     : PWM level corresponding to the next-cycle count, for registering upstream
module mda_hbridge_pwm_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             restart_i,
  input  logic [Width-1:0] period_i,
  input  logic [Width-1:0] duty_i,
  output logic             wrap_o,
  output logic             pwm_next_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] sh_period_q, sh_period_d;
  logic [Width-1:0] sh_duty_q, sh_duty_d;

  // >= rather than == so a shortened period never lets the count run past it.
  assign wrap_o = (cnt_q >= (sh_period_q - One));

  always_comb begin
    cnt_d       = '0;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    if (restart_i) begin
      sh_period_d = period_i;
      sh_duty_d   = duty_i;
    end else if (run_i) begin
      if (wrap_o) begin
        sh_period_d = period_i;
        sh_duty_d   = duty_i;
      end else begin
        cnt_d = cnt_q + One;
      end
    end
  end

  // duty >= period yields 100% since cnt never reaches period.
  assign pwm_next_o = (cnt_d < sh_duty_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
    end
  end

endmodule

// File: rtl/mda_hbridge_pwm.sv
// Per-motor H-bridge drive stage: OFF/DEAD/DRIVE sequencing with enforced dead-time on enable
// and on direction reversal, shadowed PWM, registered gate outputs.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : slave modport -- on/dir/period/duty_cycle in; gate/active/period_tick out
module mda_hbridge_pwm
  import mda_hbridge_pwm_pkg::*;
#(
  parameter int unsigned PERIOD_LENGTH   = PeriodLengthDefault,
  parameter int unsigned DEADTIME_CYCLES = DeadtimeDefault
) (
  input  logic              clk,
  input  logic              reset,
  mda_hbridge_pwm_if.slave  bus
);

  localparam int unsigned    DeadW    = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DeadW-1:0] DeadLoad = DeadW'(DEADTIME_CYCLES);
  localparam logic [DeadW-1:0] DeadOne  = DeadW'(1);

  state_e           state_q, state_d;
  logic [DeadW-1:0] dead_q, dead_d;
  logic             dir_q, dir_d;
  logic [3:0]       gate_q, gate_d;
  logic             active_q, active_d;
  logic             tick_q, tick_d;

  logic run, restart, wrap, pwm_next, period_zero;

  assign period_zero = (bus.period == '0);

  mda_hbridge_pwm_counter #(
    .Width (PERIOD_LENGTH)
  ) u_counter (
    .clk_i      (clk),
    .rst_ni     (reset),
    .run_i      (run),
    .restart_i  (restart),
    .period_i   (bus.period),
    .duty_i     (bus.duty_cycle),
    .wrap_o     (wrap),
    .pwm_next_o (pwm_next)
  );

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    dir_d   = dir_q;
    run     = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      StOff: begin
        if (bus.on && !period_zero) begin
          state_d = StDead;
          dir_d   = bus.dir;
          dead_d  = DeadLoad;
        end
      end
      StDead: begin
        if (!bus.on || period_zero) begin
          state_d = StOff;
        end else if (bus.dir != dir_q) begin
          // Reversal mid dead-time restarts the full dead-time.
          dir_d  = bus.dir;
          dead_d = DeadLoad;
        end else if (dead_q <= DeadOne) begin
          state_d = StDrive;
          dead_d  = '0;
          restart = 1'b1;
        end else begin
          dead_d = dead_q - DeadOne;
        end
      end
      StDrive: begin
        if (!bus.on || period_zero) begin
          state_d = StOff;
        end else if (bus.dir != dir_q) begin
          state_d = StDead;
          dir_d   = bus.dir;
          dead_d  = DeadLoad;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = StOff;
    endcase

    // Outputs are registered from next-state so they line up with the state they describe.
    gate_d   = (state_d == StDrive) ? gate_map(dir_d, pwm_next) : 4'b0000;
    active_d = (state_d == StDrive);
    tick_d   = run && wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StOff;
      dead_q   <= '0;
      dir_q    <= 1'b0;
      gate_q   <= 4'b0000;
      active_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dead_q   <= dead_d;
      dir_q    <= dir_d;
      gate_q   <= gate_d;
      active_q <= active_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.gate        = gate_q;
  assign bus.active      = active_q;
  assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_mda_hbridge_pwm.sv
// Bench for mda_hbridge_pwm: a cycle-level behavioural model checked every clock, plus
// directed scenarios with hand-computed literal expectations.
module tb_mda_hbridge_pwm;

  localparam int DEAD = 50;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  mda_hbridge_pwm_if #(.PERIOD_LENGTH(16)) bus ();

  mda_hbridge_pwm #(
    .PERIOD_LENGTH   (16),
    .DEADTIME_CYCLES (DEAD)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 = off, 1 = dead-time, 2 = driving
  int         m_mode, m_elapsed, m_phase, m_duty, m_period;
  bit         m_dir;
  logic [3:0] e_gate;
  logic       e_act, e_tick;

  task automatic model_step();
    e_tick = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_elapsed = 0; m_phase = 0; m_duty = 0; m_period = 0; m_dir = 1'b0;
    end else begin
      case (m_mode)
        0: if (bus.on && bus.period != 0) begin
             m_mode = 1; m_dir = bus.dir; m_elapsed = 0;
           end
        1: if (!bus.on || bus.period == 0) m_mode = 0;
           else if (bus.dir != m_dir) begin
             m_dir = bus.dir; m_elapsed = 0;
           end else if (m_elapsed + 1 >= DEAD) begin
             m_mode = 2; m_phase = 0; m_duty = int'(bus.duty_cycle); m_period = int'(bus.period);
           end else m_elapsed++;
        default: if (!bus.on || bus.period == 0) m_mode = 0;
           else if (bus.dir != m_dir) begin
             m_mode = 1; m_dir = bus.dir; m_elapsed = 0;
           end else if (m_phase + 1 >= m_period) begin
             m_phase = 0; e_tick = 1'b1;
             m_duty = int'(bus.duty_cycle); m_period = int'(bus.period);
           end else m_phase++;
      endcase
    end
    e_act  = (m_mode == 2);
    e_gate = 4'b0000;
    if (m_mode == 2) begin
      if (!m_dir) e_gate = {1'b1, 1'b0, 1'b0, (m_phase < m_duty)};
      else        e_gate = {1'b0, (m_phase < m_duty), 1'b1, 1'b0};
    end
  endtask

  // Per-cycle compare against the model, plus the shoot-through invariant.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      n_vec++;
      if (bus.gate !== e_gate || bus.active !== e_act || bus.period_tick !== e_tick) begin
        n_fail++;
        $display("FAIL model_cycle @%0t: gate=%b active=%b tick=%b, expected gate=%b active=%b tick=%b",
                 $time, bus.gate, bus.active, bus.period_tick, e_gate, e_act, e_tick);
      end
      n_vec++;
      if ((bus.gate[0] & bus.gate[1]) | (bus.gate[2] & bus.gate[3])) begin
        n_fail++;
        $display("FAIL shoot_through @%0t: gate=%b, expected no leg with both switches on",
                 $time, bus.gate);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Count sampled cycles with all gates low until any gate rises.
  task automatic count_dead(output int n);
    n = 0;
    sample();
    while (bus.gate == 4'b0000 && n < 200) begin
      n++;
      sample();
    end
  endtask

  task automatic wait_tick(output int n, output int hi);
    n = 0; hi = 0;
    sample();
    while (!bus.period_tick && n < 300) begin
      n++;
      hi += int'(bus.gate[0]);
      sample();
    end
  endtask

  // Counts over 100 samples, the first being the current one.
  task automatic count_period(input int bit_idx, input int const_idx, output int hi, output int c);
    hi = 0; c = 1;
    for (int i = 0; i < 100; i++) begin
      if (i != 0) sample();
      hi += int'(bus.gate[bit_idx]);
      c  &= int'(bus.gate[const_idx]);
    end
  endtask

  int n, hi, c, acc;

  initial begin
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.on = 1'b1; bus.dir = 1'b0; bus.period = 16'd100; bus.duty_cycle = 16'd25;

    // 1. Reset holds everything low even with on=1; then dead-time, then 25/100 forward.
    repeat (3) @(negedge clk);
    check("reset_gate", int'(bus.gate), 0);
    check("reset_active", int'(bus.active), 0);
    check("reset_tick", int'(bus.period_tick), 0);
    rst_n = 1'b1;
    count_dead(n);
    check("enable_dead_len", n, 50);
    count_period(0, 3, hi, c);
    check("fwd_ahi_25", hi, 25);
    check("fwd_blo_const", c, 1);

    // 2. Duty raised mid-period takes effect only at the next wrap.
    repeat (10) sample();
    @(negedge clk); bus.duty_cycle = 16'd75;
    wait_tick(n, hi);
    check("rest_of_period_len", n, 90);
    check("rest_of_period_hi", hi, 15);
    check("tick_gate_high", int'(bus.gate[0]), 1);
    count_period(0, 3, hi, c);
    check("new_duty_75", hi, 75);

    // 3. Reversal: full dead-time, then reverse drive.
    @(negedge clk); bus.dir = 1'b1;
    count_dead(n);
    check("reverse_dead_len", n, 50);
    count_period(2, 1, hi, c);
    check("rev_bhi_75", hi, 75);
    check("rev_alo_const", c, 1);

    // 4. Duty extremes (back to forward).
    @(negedge clk); bus.dir = 1'b0; bus.duty_cycle = 16'd0;
    count_dead(n);
    check("fwd_again_dead_len", n, 50);
    count_period(0, 3, hi, c);
    check("duty0_never_high", hi, 0);
    check("duty0_blo_const", c, 1);
    @(negedge clk); bus.duty_cycle = 16'd100;
    wait_tick(n, hi);
    count_period(0, 3, hi, c);
    check("duty100_full", hi, 100);
    @(negedge clk); bus.duty_cycle = 16'd200;
    wait_tick(n, hi);
    count_period(0, 3, hi, c);
    check("duty200_full", hi, 100);

    // 5. on=0 with simultaneous dir toggle: straight to off, no dead-time/drive afterwards.
    @(negedge clk); bus.on = 1'b0; bus.dir = 1'b1;
    sample();
    check("off_gate", int'(bus.gate), 0);
    check("off_active", int'(bus.active), 0);
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      sample();
      acc += int'(bus.active) + int'(bus.gate != 4'b0000);
    end
    check("off_stays_off", acc, 0);

    // 6. period=0 blocks enable; writing period=0 while driving turns off next clock.
    @(negedge clk); bus.on = 1'b1; bus.dir = 1'b0; bus.period = 16'd0; bus.duty_cycle = 16'd25;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      sample();
      acc += int'(bus.active) + int'(bus.gate != 4'b0000);
    end
    check("period0_stays_off", acc, 0);
    @(negedge clk); bus.period = 16'd100;
    count_dead(n);
    check("period_set_dead_len", n, 50);
    check("period_set_active", int'(bus.active), 1);
    repeat (5) sample();
    @(negedge clk); bus.period = 16'd0;
    sample();
    check("period0_drive_active", int'(bus.active), 0);
    check("period0_drive_gate", int'(bus.gate), 0);

    // Reset mid-period clears gates immediately, without waiting for a clock.
    @(negedge clk); bus.period = 16'd100;
    count_dead(n);
    repeat (10) sample();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_gate", int'(bus.gate), 0);
    check("async_reset_active", int'(bus.active), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dead(n);
    check("after_reset_dead_len", n, 50);
    repeat (20) sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
